// File: rtl/step_phase_monitor.sv
// Receive-side monitor for a two-phase stepper bus {B',A',B,A}: sync, debounce, decode to position.
// Optional reversal tracking is built only when STEP_MON_REV_EN is defined.
module step_phase_monitor #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned POS_W        = 16,
    parameter int unsigned STALL_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       phase_i,
    input  logic             clr_i,
    output logic [POS_W-1:0] pos_o,
    output logic             dir_o,
    output logic             step_o,
    output logic             moving_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic             rev_o,
    output logic [7:0]       rev_cnt_o
);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1) + 1;
    localparam int unsigned MOV_W = $clog2(STALL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOCKED, FAULT} state_t;

    // Returns {legal, index} where index walks 0..3 in the forward direction.
    function automatic logic [2:0] code_idx(input logic [3:0] c);
        case (c)
            4'b0011: code_idx = 3'b100;
            4'b0110: code_idx = 3'b101;
            4'b1100: code_idx = 3'b110;
            4'b1001: code_idx = 3'b111;
            default: code_idx = 3'b000;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]       s, s_q, acc_code, prev_code;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic             acc_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], phase_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        deb_cnt_nxt = (s != s_q) ? DEB_W'(1) : deb_cnt + DEB_W'(1);
    end

    // acc_v marks the cycle after acceptance; prev_code keeps the code it replaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q       <= '0;
            acc_code  <= '0;
            prev_code <= '0;
            deb_cnt   <= '0;
            acc_v     <= 1'b0;
        end else begin
            s_q   <= s;
            acc_v <= 1'b0;
            if (s == acc_code) begin
                deb_cnt <= '0;
            end else if (deb_cnt_nxt >= DEB_W'(DEB_CYCLES)) begin
                deb_cnt   <= '0;
                acc_code  <= s;
                prev_code <= acc_code;
                acc_v     <= 1'b1;
            end else begin
                deb_cnt <= deb_cnt_nxt;
            end
        end
    end

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_d;
    logic             dir_d, step_d;
    logic [1:0]       code_d;
    logic [2:0]       new_i, old_i;
    logic [1:0]       delta;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_o;
        dir_d   = dir_o;
        step_d  = 1'b0;
        code_d  = err_code_o;
        new_i   = code_idx(acc_code);
        old_i   = code_idx(prev_code);
        delta   = new_i[1:0] - old_i[1:0];
        if (clr_i) begin
            state_d = IDLE;
            pos_d   = '0;
            code_d  = 2'b00;
        end else if (acc_v) begin
            case (state_q)
                IDLE: begin
                    if (new_i[2]) begin
                        state_d = LOCKED;
                    end else if (acc_code != 4'b0000) begin
                        state_d = FAULT;
                        code_d  = 2'b01;
                    end
                end
                LOCKED: begin
                    if (acc_code == 4'b0000) begin
                        state_d = IDLE;
                    end else if (!new_i[2]) begin
                        state_d = FAULT;
                        code_d  = 2'b01;
                    end else if (delta == 2'd1) begin
                        pos_d  = pos_o + POS_W'(1);
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                    end else if (delta == 2'd3) begin
                        pos_d  = pos_o - POS_W'(1);
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                    end else begin
                        state_d = FAULT;
                        code_d  = 2'b10;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pos_o      <= '0;
            dir_o      <= 1'b0;
            step_o     <= 1'b0;
            err_code_o <= 2'b00;
        end else begin
            state_q    <= state_d;
            pos_o      <= pos_d;
            dir_o      <= dir_d;
            step_o     <= step_d;
            err_code_o <= code_d;
        end
    end

    assign err_o = (state_q == FAULT);

    // Reload on the edge that raises step_o so moving_o rises together with it.
    logic [MOV_W-1:0] mov_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mov_cnt <= '0;
        end else if (step_d) begin
            mov_cnt <= MOV_W'(STALL_CYCLES);
        end else if (mov_cnt != '0) begin
            mov_cnt <= mov_cnt - MOV_W'(1);
        end
    end

    assign moving_o = (mov_cnt != '0);

`ifdef STEP_MON_REV_EN
    logic       have_dir_q, rev_q, rev_d;
    logic [7:0] rev_cnt_q;

    assign rev_d = step_d && have_dir_q && (dir_d != dir_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_dir_q <= 1'b0;
            rev_q      <= 1'b0;
            rev_cnt_q  <= '0;
        end else begin
            rev_q <= rev_d;
            if (clr_i) begin
                have_dir_q <= 1'b0;
                rev_cnt_q  <= '0;
            end else begin
                if (step_d) begin
                    have_dir_q <= 1'b1;
                end
                if (rev_d && (rev_cnt_q != 8'hFF)) begin
                    rev_cnt_q <= rev_cnt_q + 8'd1;
                end
            end
        end
    end

    assign rev_o     = rev_q;
    assign rev_cnt_o = rev_cnt_q;
`else
    assign rev_o     = 1'b0;
    assign rev_cnt_o = '0;
`endif

endmodule

// File: tb/tb_step_phase_monitor.sv
// Scoreboard bench for step_phase_monitor: directed phase sequences, step events checked by a monitor.
module tb_step_phase_monitor;
`ifdef STEP_MON_REV_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_i;
    logic [3:0]  phase, phase_s;
    logic [15:0] pos_o;
    logic        dir_o, step_o, moving_o, err_o, rev_o;
    logic [1:0]  err_code_o;
    logic [7:0]  rev_cnt_o;
    logic [7:0]  pos_s;
    logic        dir_s, step_s, moving_s, err_s, rev_s;
    logic [1:0]  code_s;
    logic [7:0]  rcnt_s;

    always #10 clk = ~clk;

    step_phase_monitor u_dut (
        .clk(clk), .rst(rst), .phase_i(phase), .clr_i(clr_i),
        .pos_o(pos_o), .dir_o(dir_o), .step_o(step_o), .moving_o(moving_o),
        .err_o(err_o), .err_code_o(err_code_o), .rev_o(rev_o), .rev_cnt_o(rev_cnt_o)
    );

    step_phase_monitor #(.POS_W(8), .STALL_CYCLES(100)) u_small (
        .clk(clk), .rst(rst), .phase_i(phase_s), .clr_i(1'b0),
        .pos_o(pos_s), .dir_o(dir_s), .step_o(step_s), .moving_o(moving_s),
        .err_o(err_s), .err_code_o(code_s), .rev_o(rev_s), .rev_cnt_o(rcnt_s)
    );

    typedef struct {
        logic [15:0] pos;
        logic        dir;
        logic        rev;
        logic [7:0]  rcnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    bit   have_dir = 1'b0;
    bit   last_dir = 1'b0;
    int   exp_rev_cnt = 0;
    logic [3:0] fwd [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_step(input logic [15:0] p, input logic d);
        exp_t e;
        e.pos = p;
        e.dir = d;
        e.rev = REV_EN && have_dir && (d != last_dir);
        if (e.rev && exp_rev_cnt < 255) exp_rev_cnt++;
        e.rcnt = REV_EN ? 8'(exp_rev_cnt) : 8'd0;
        have_dir = 1'b1;
        last_dir = d;
        sb.push_back(e);
    endtask

    task automatic model_clear();
        have_dir = 1'b0;
        exp_rev_cnt = 0;
    endtask

    task automatic drive(input logic [3:0] c, input int hold);
        phase = c;
        repeat (hold) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        model_clear();
    endtask

    // Monitor: every step_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (step_o) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL step_unexpected: got pos=%h dir=%b, required no step", pos_o, dir_o);
            end else begin
                mon_e = sb.pop_front();
                if ({pos_o, dir_o, rev_o, rev_cnt_o} !== {mon_e.pos, mon_e.dir, mon_e.rev, mon_e.rcnt}) begin
                    miscompares++;
                    $display("FAIL step_event: got pos=%h dir=%b rev=%b rcnt=%0d, required pos=%h dir=%b rev=%b rcnt=%0d",
                             pos_o, dir_o, rev_o, rev_cnt_o, mon_e.pos, mon_e.dir, mon_e.rev, mon_e.rcnt);
                end
            end
        end else if (rev_o) begin
            vectors++;
            miscompares++;
            $display("FAIL rev_without_step: got rev_o=1, required 0");
        end
    end

    initial begin
        int lat;
        int n;
        bit seen;
        rst = 1'b1;
        clr_i = 1'b0;
        phase = 4'b0000;
        phase_s = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_pos", 32'(pos_o), 0);
        chk("rst_dir", 32'(dir_o), 0);
        chk("rst_step", 32'(step_o), 0);
        chk("rst_moving", 32'(moving_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_code", 32'(err_code_o), 0);
        chk("rst_rev", 32'(rev_o), 0);
        chk("rst_rcnt", 32'(rev_cnt_o), 0);
        rst = 1'b0;

        // Forward cycle
        drive(4'b0011, 20);
        chk("lock_no_step_pos", 32'(pos_o), 0);
        expect_step(16'd1, 1'b1); drive(4'b0110, 20);
        expect_step(16'd2, 1'b1); drive(4'b1100, 20);
        expect_step(16'd3, 1'b1); drive(4'b1001, 20);
        expect_step(16'd4, 1'b1); drive(4'b0011, 20);
        chk("fwd_pos", 32'(pos_o), 4);
        chk("fwd_dir", 32'(dir_o), 1);
        chk("fwd_err", 32'(err_o), 0);
        chk("fwd_moving", 32'(moving_o), 1);

        // Asynchronous reset mid-cycle, then latency
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_pos", 32'(pos_o), 0);
        chk("async_rst_moving", 32'(moving_o), 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        drive(4'b0011, 20);
        expect_step(16'd1, 1'b1);
        phase = 4'b0110;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (step_o && lat < 0) lat = k;
        end
        chk("step_latency", 32'(lat), 6);
        chk("lat_pos", 32'(pos_o), 1);

        // Short glitch must not be accepted
        phase = 4'b1100;
        repeat (3) @(negedge clk);
        drive(4'b0110, 20);
        chk("glitch_pos", 32'(pos_o), 1);

        // Backward steps through zero
        expect_step(16'd0, 1'b0); drive(4'b0011, 20);
        expect_step(16'hFFFF, 1'b0); drive(4'b1001, 20);
        chk("underflow_pos", 32'(pos_o), 32'h0000FFFF);
        chk("back_dir", 32'(dir_o), 0);
        expect_step(16'd0, 1'b1); drive(4'b0011, 20);
        expect_step(16'd1, 1'b1); drive(4'b0110, 20);
        expect_step(16'd2, 1'b1); drive(4'b1100, 20);
        expect_step(16'd3, 1'b1); drive(4'b1001, 20);
        expect_step(16'd4, 1'b1); drive(4'b0011, 20);

        // Skipped step (opposite code) then fault freeze
        drive(4'b1100, 20);
        chk("skip_err", 32'(err_o), 1);
        chk("skip_code", 32'(err_code_o), 2);
        chk("skip_pos", 32'(pos_o), 4);
        drive(4'b0101, 20);
        chk("fault_code_sticky", 32'(err_code_o), 2);
        drive(4'b0110, 20);
        chk("fault_pos_frozen", 32'(pos_o), 4);
        pulse_clr();
        chk("clr_err", 32'(err_o), 0);
        chk("clr_code", 32'(err_code_o), 0);
        chk("clr_pos", 32'(pos_o), 0);

        // IDLE behaviour
        drive(4'b0000, 20);
        chk("idle_zero_err", 32'(err_o), 0);
        drive(4'b0111, 20);
        chk("idle_illegal_err", 32'(err_o), 1);
        chk("idle_illegal_code", 32'(err_code_o), 1);
        pulse_clr();
        drive(4'b0011, 20);
        chk("relock_pos", 32'(pos_o), 0);
        expect_step(16'd1, 1'b1); drive(4'b0110, 20);
        drive(4'b0000, 20);
        chk("deenergize_pos", 32'(pos_o), 1);
        drive(4'b1100, 20);
        chk("idle_lock_pos", 32'(pos_o), 1);
        expect_step(16'd2, 1'b1); drive(4'b1001, 20);
        chk("after_relock_pos", 32'(pos_o), 2);

        // clr_i coinciding with an acceptance drops the step
        phase = 4'b0011;
        for (int k = 0; k < 6; k++) @(negedge clk);
        pulse_clr();
        repeat (12) @(negedge clk);
        chk("clr_prio_pos", 32'(pos_o), 0);
        drive(4'b0110, 20);
        chk("clr_prio_idle_pos", 32'(pos_o), 0);
        expect_step(16'd1, 1'b1); drive(4'b1100, 20);
        drive(4'b1111, 20);
        chk("locked_illegal_code", 32'(err_code_o), 1);
        chk("locked_illegal_pos", 32'(pos_o), 1);
        pulse_clr();

        // Wrap and stall on the narrow instance
        drive(4'b0011, 1);
        phase_s = 4'b0011;
        repeat (20) @(negedge clk);
        for (int i = 1; i < 128; i++) begin
            phase_s = fwd[i % 4];
            repeat (8) @(negedge clk);
        end
        chk("small_pos_7f", 32'(pos_s), 32'h7F);
        phase_s = fwd[0];
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (step_s) seen = 1'b1;
        end
        chk("small_step_seen", 32'(seen), 1);
        chk("small_wrap_pos", 32'(pos_s), 32'h80);
        chk("small_wrap_dir", 32'(dir_s), 1);
        n = 0;
        while (moving_s && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("small_stall_cycles", 32'(n), 100);
        chk("small_err", 32'(err_s), 0);

        // Forward then backward run for reversal tracking
        phase = 4'b0011;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 100; i++) begin
            expect_step(16'(i), 1'b1);
            drive(fwd[i % 4], 8);
        end
        for (int j = 1; j <= 100; j++) begin
            expect_step(16'(100 - j), 1'b0);
            drive(fwd[(100 - j) % 4], 8);
        end
        chk("rev_run_pos", 32'(pos_o), 0);
        chk("rev_run_cnt", 32'(rev_cnt_o), REV_EN ? 1 : 0);
        chk("rev_run_moving", 32'(moving_o), 1);

        repeat (10) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
